mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 37 +++
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch port, data port, branch flush, stall outputs and the
// byte-wide RAM bus. The controller uses the slave view; the environment
// that drives requests and models the RAM uses the master view.
interface mem_ctrl_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_len;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        flush_from_branch;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic        stall_req_if;
   logic        stall_req_mem;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata,
             flush_from_branch, ram_din,
      output if_inst, if_done, mem_rdata, mem_done, ram_dout, ram_addr, ram_wr,
             stall_req_if, stall_req_mem
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata,
             flush_from_branch, ram_din,
      input  if_inst, if_done, mem_rdata, mem_done, ram_dout, ram_addr, ram_wr,
             stall_req_if, stall_req_mem
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates an instruction fetch port and a
// data port onto a byte-wide RAM with one cycle of read latency. Fetches are
// 4-byte big-endian words; data accesses are 1/2/4-byte little-endian.
module mem_ctrl (
   input  logic      clk,
   input  logic      rst,
   mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state_reg;
   logic [2:0]  cnt_reg;
   logic [2:0]  len_reg;
   logic [31:0] base_reg;
   logic [31:0] wdata_reg;
   logic        owner_if_reg;
   logic [7:0]  rbuf_reg [0:2];
   logic [31:0] if_inst_reg;
   logic [31:0] mem_rdata_reg;
   logic [31:0] ram_addr_reg;
   logic [7:0]  ram_dout_reg;
   logic        if_done_reg;
   logic        mem_done_reg;
   logic        ram_wr_reg;

   logic [2:0]  cnt_next;
   logic [1:0]  rbuf_idx;
   logic [2:0]  mem_len_n;
   logic [7:0]  wbyte [0:3];

   assign cnt_next  = cnt_reg + 3'd1;
   // Byte k is on ram_din while cnt_reg = k+1, so it lands in slot cnt_reg-1.
   assign rbuf_idx  = cnt_reg[1:0] - 2'd1;
   assign mem_len_n = (bus.mem_len == 2'b00) ? 3'd1 :
                      (bus.mem_len == 2'b01) ? 3'd2 : 3'd4;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wbyte
         assign wbyte[gi] = wdata_reg[8*gi +: 8];
      end
   endgenerate

   assign bus.if_inst       = if_inst_reg;
   assign bus.if_done       = if_done_reg;
   assign bus.mem_rdata     = mem_rdata_reg;
   assign bus.mem_done      = mem_done_reg;
   assign bus.ram_addr      = ram_addr_reg;
   assign bus.ram_dout      = ram_dout_reg;
   assign bus.ram_wr        = ram_wr_reg;
   assign bus.stall_req_if  = bus.if_req & ~if_done_reg;
   assign bus.stall_req_mem = bus.mem_req & ~mem_done_reg;

   // Transfer FSM: RAM bus outputs and done pulses are registered so that
   // each cycle's RAM address is prepared on the preceding clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 3'd0;
         len_reg       <= 3'd0;
         base_reg      <= 32'd0;
         wdata_reg     <= 32'd0;
         owner_if_reg  <= 1'b0;
         if_inst_reg   <= 32'd0;
         mem_rdata_reg <= 32'd0;
         ram_addr_reg  <= 32'd0;
         ram_dout_reg  <= 8'd0;
         if_done_reg   <= 1'b0;
         mem_done_reg  <= 1'b0;
         ram_wr_reg    <= 1'b0;
      end else begin
         if_done_reg  <= 1'b0;
         mem_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               cnt_reg <= 3'd0;
               if (bus.mem_req) begin
                  base_reg     <= bus.mem_addr;
                  len_reg      <= mem_len_n;
                  wdata_reg    <= bus.mem_wdata;
                  owner_if_reg <= 1'b0;
                  ram_addr_reg <= bus.mem_addr;
                  if (bus.mem_we) begin
                     state_reg    <= WR;
                     ram_wr_reg   <= 1'b1;
                     ram_dout_reg <= bus.mem_wdata[7:0];
                  end else begin
                     state_reg <= RD;
                  end
               end else if (bus.if_req && !bus.flush_from_branch) begin
                  base_reg     <= bus.if_addr;
                  len_reg      <= 3'd4;
                  owner_if_reg <= 1'b1;
                  ram_addr_reg <= bus.if_addr;
                  state_reg    <= RD;
               end
            end
            RD: begin
               if (owner_if_reg && bus.flush_from_branch) begin
                  // Abandon the fetch; if_inst keeps its last completed word.
                  state_reg    <= IDLE;
                  cnt_reg      <= 3'd0;
                  ram_addr_reg <= 32'd0;
               end else if (cnt_reg == len_reg) begin
                  // Last byte is still on ram_din: merge it straight in.
                  if (owner_if_reg) begin
                     if_inst_reg <= {rbuf_reg[0], rbuf_reg[1], rbuf_reg[2], bus.ram_din};
                     if_done_reg <= 1'b1;
                  end else begin
                     case (len_reg)
                        3'd1:    mem_rdata_reg <= {24'h0, bus.ram_din};
                        3'd2:    mem_rdata_reg <= {16'h0, bus.ram_din, rbuf_reg[0]};
                        default: mem_rdata_reg <= {bus.ram_din, rbuf_reg[2], rbuf_reg[1], rbuf_reg[0]};
                     endcase
                     mem_done_reg <= 1'b1;
                  end
                  state_reg <= DONE;
                  cnt_reg   <= 3'd0;
               end else begin
                  if (cnt_reg != 3'd0) begin
                     rbuf_reg[rbuf_idx] <= bus.ram_din;
                  end
                  cnt_reg      <= cnt_next;
                  ram_addr_reg <= (cnt_next < len_reg) ? base_reg + {29'd0, cnt_next} : 32'd0;
               end
            end
            WR: begin
               if (cnt_next < len_reg) begin
                  cnt_reg      <= cnt_next;
                  ram_addr_reg <= base_reg + {29'd0, cnt_next};
                  ram_dout_reg <= wbyte[cnt_next[1:0]];
               end else begin
                  state_reg    <= DONE;
                  cnt_reg      <= 3'd0;
                  ram_wr_reg   <= 1'b0;
                  ram_addr_reg <= 32'd0;
                  ram_dout_reg <= 8'd0;
                  mem_done_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model of one-cycle read latency.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mem_ctrl_if bus();

   mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Bytes written by the DUT; untouched addresses fall back to preload.
   logic [7:0] wr_mem [bit [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 8'h13;
         32'h0000_0200: return 8'h78;
         32'h0000_0201: return 8'h56;
         32'h0000_0202: return 8'h34;
         32'h0000_0203: return 8'h12;
         32'h0000_0300: return 8'h11;
         32'h0000_0301: return 8'h22;
         32'h0000_0302: return 8'h33;
         32'h0000_0303: return 8'h44;
         32'h0000_0400: return 8'h55;
         32'h0000_0401: return 8'h66;
         32'h0000_0402: return 8'h77;
         32'h0000_0403: return 8'h88;
         32'hFFFF_FFFF: return 8'hA5;
         32'h0000_0000: return 8'h3C;
         default:       return 8'h00;
      endcase
   endfunction

   // RAM model: read data appears the cycle after its address.
   always @(posedge clk) begin
      if (bus.ram_wr === 1'b1) wr_mem[bus.ram_addr] = bus.ram_dout;
      bus.ram_din <= wr_mem.exists(bus.ram_addr) ? wr_mem[bus.ram_addr] : init_byte(bus.ram_addr);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) next_cycle();
      total++; if (bus.ram_wr !== 1'b0) begin bad++; $display("FAIL reset_ram_wr: got %b want 0", bus.ram_wr); end
      total++; if (bus.ram_addr !== 32'h0) begin bad++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr); end
      total++; if (bus.ram_dout !== 8'h0) begin bad++; $display("FAIL reset_ram_dout: got %h want 0", bus.ram_dout); end
      total++; if (bus.if_done !== 1'b0 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b%b want 00", bus.if_done, bus.mem_done); end
      total++; if (bus.if_inst !== 32'h0) begin bad++; $display("FAIL reset_if_inst: got %h want 0", bus.if_inst); end
      total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
      rst = 1'b0;
      next_cycle();
      $display("test_reset done");
   endtask

   task automatic test_fetch();
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      #1;
      total++; if (bus.stall_req_if !== 1'b1) begin bad++; $display("FAIL fetch_stall_t0: got %b want 1", bus.stall_req_if); end
      for (int k = 1; k <= 6; k++) begin
         next_cycle();
         if (k <= 4) begin
            total++;
            if (bus.ram_addr !== 32'(32'h100 + k - 1) || bus.ram_wr !== 1'b0) begin
               bad++; $display("FAIL fetch_addr_t%0d: got %h wr=%b want %h wr=0", k, bus.ram_addr, bus.ram_wr, 32'(32'h100 + k - 1));
            end
         end
         if (k < 6) begin
            total++;
            if (bus.if_done !== 1'b0 || bus.stall_req_if !== 1'b1) begin
               bad++; $display("FAIL fetch_busy_t%0d: got done=%b stall=%b want done=0 stall=1", k, bus.if_done, bus.stall_req_if);
            end
         end
      end
      total++; if (bus.if_done !== 1'b1) begin bad++; $display("FAIL fetch_done_t6: got %b want 1", bus.if_done); end
      total++; if (bus.if_inst !== 32'h1300_0000) begin bad++; $display("FAIL fetch_inst: got %h want 13000000", bus.if_inst); end
      total++; if (bus.stall_req_if !== 1'b0 || bus.ram_addr !== 32'h0) begin bad++; $display("FAIL fetch_t6_idle_bus: got stall=%b addr=%h want 0 0", bus.stall_req_if, bus.ram_addr); end
      bus.if_req = 1'b0;
      next_cycle();
      total++; if (bus.if_done !== 1'b0 || bus.if_inst !== 32'h1300_0000) begin bad++; $display("FAIL fetch_hold_t7: got done=%b inst=%h want 0 13000000", bus.if_done, bus.if_inst); end
      $display("test_fetch done");
   endtask

   task automatic test_simultaneous();
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b10; bus.mem_addr = 32'h200;
      for (int k = 1; k <= 6; k++) begin
         next_cycle();
         if (k <= 4) begin
            total++;
            if (bus.ram_addr !== 32'(32'h200 + k - 1)) begin bad++; $display("FAIL simul_addr_t%0d: got %h want %h", k, bus.ram_addr, 32'(32'h200 + k - 1)); end
         end
         if (k < 6) begin
            total++;
            if (bus.mem_done !== 1'b0 || bus.if_done !== 1'b0) begin bad++; $display("FAIL simul_busy_t%0d: got mem=%b if=%b want 0 0", k, bus.mem_done, bus.if_done); end
         end
      end
      total++; if (bus.mem_done !== 1'b1 || bus.if_done !== 1'b0) begin bad++; $display("FAIL simul_done_t6: got mem=%b if=%b want 1 0", bus.mem_done, bus.if_done); end
      total++; if (bus.mem_rdata !== 32'h1234_5678) begin bad++; $display("FAIL simul_rdata: got %h want 12345678", bus.mem_rdata); end
      bus.mem_req = 1'b0;
      next_cycle();
      total++; if (bus.ram_addr !== 32'h0 || bus.mem_done !== 1'b0) begin bad++; $display("FAIL simul_t7_idle: got addr=%h done=%b want 0 0", bus.ram_addr, bus.mem_done); end
      next_cycle();
      total++; if (bus.ram_addr !== 32'h100) begin bad++; $display("FAIL simul_fetch_t8: got %h want 00000100", bus.ram_addr); end
      repeat (5) next_cycle();
      total++; if (bus.if_done !== 1'b1 || bus.if_inst !== 32'h1300_0000) begin bad++; $display("FAIL simul_fetch_t13: got done=%b inst=%h want 1 13000000", bus.if_done, bus.if_inst); end
      bus.if_req = 1'b0;
      next_cycle();
      $display("test_simultaneous done");
   endtask

   task automatic test_byte_write();
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b00;
      bus.mem_addr = 32'h3; bus.mem_wdata = 32'hAABB_CCDD;
      next_cycle();
      total++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== {1'b1, 32'h3, 8'hDD}) begin bad++; $display("FAIL bw_t1: got wr=%b addr=%h dout=%h want 1 00000003 dd", bus.ram_wr, bus.ram_addr, bus.ram_dout); end
      total++; if (bus.mem_done !== 1'b0) begin bad++; $display("FAIL bw_done_t1: got %b want 0", bus.mem_done); end
      next_cycle();
      total++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== 41'h0) begin bad++; $display("FAIL bw_t2_bus: got wr=%b addr=%h dout=%h want 0 0 0", bus.ram_wr, bus.ram_addr, bus.ram_dout); end
      total++; if (bus.mem_done !== 1'b1) begin bad++; $display("FAIL bw_done_t2: got %b want 1", bus.mem_done); end
      total++; if (bus.mem_rdata !== 32'h1234_5678) begin bad++; $display("FAIL bw_rdata_hold: got %h want 12345678", bus.mem_rdata); end
      bus.mem_req = 1'b0; bus.mem_we = 1'b0;
      next_cycle();
      total++; if (!wr_mem.exists(32'h3) || wr_mem[32'h3] !== 8'hDD || wr_mem.exists(32'h4)) begin bad++; $display("FAIL bw_ram_contents: byte3 present=%0d byte4 present=%0d want 1 0 with dd", wr_mem.exists(32'h3), wr_mem.exists(32'h4)); end
      total++; if (bus.mem_done !== 1'b0) begin bad++; $display("FAIL bw_done_t3: got %b want 0", bus.mem_done); end
      $display("test_byte_write done");
   endtask

   task automatic test_flush();
      bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.flush_from_branch = 1'b1;
      next_cycle();
      total++; if (bus.ram_addr !== 32'h0) begin bad++; $display("FAIL flush_blocks_accept: got %h want 0", bus.ram_addr); end
      bus.flush_from_branch = 1'b0;
      next_cycle();
      total++; if (bus.ram_addr !== 32'h300) begin bad++; $display("FAIL flush_t1: got %h want 00000300", bus.ram_addr); end
      next_cycle();
      total++; if (bus.ram_addr !== 32'h301) begin bad++; $display("FAIL flush_t2: got %h want 00000301", bus.ram_addr); end
      bus.flush_from_branch = 1'b1;
      next_cycle();
      total++; if (bus.ram_addr !== 32'h0 || bus.if_done !== 1'b0) begin bad++; $display("FAIL flush_t3_idle: got addr=%h done=%b want 0 0", bus.ram_addr, bus.if_done); end
      bus.flush_from_branch = 1'b0; bus.if_addr = 32'h400;
      next_cycle();
      total++; if (bus.ram_addr !== 32'h400) begin bad++; $display("FAIL flush_refetch_t4: got %h want 00000400", bus.ram_addr); end
      for (int k = 5; k <= 8; k++) begin
         next_cycle();
         total++;
         if (bus.if_done !== 1'b0 || bus.if_inst !== 32'h1300_0000) begin bad++; $display("FAIL flush_hold_t%0d: got done=%b inst=%h want 0 13000000", k, bus.if_done, bus.if_inst); end
      end
      next_cycle();
      total++; if (bus.if_done !== 1'b1 || bus.if_inst !== 32'h5566_7788) begin bad++; $display("FAIL flush_refetch_done: got done=%b inst=%h want 1 55667788", bus.if_done, bus.if_inst); end
      bus.if_req = 1'b0;
      next_cycle();
      $display("test_flush done");
   endtask

   task automatic test_halfword_wrap();
      // Flush held high throughout: it must not disturb a data access.
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'b01;
      bus.mem_addr = 32'hFFFF_FFFF; bus.flush_from_branch = 1'b1;
      next_cycle();
      total++; if (bus.ram_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hw_addr_t1: got %h want ffffffff", bus.ram_addr); end
      next_cycle();
      total++; if (bus.ram_addr !== 32'h0) begin bad++; $display("FAIL hw_addr_t2: got %h want 00000000", bus.ram_addr); end
      next_cycle();
      total++; if (bus.mem_done !== 1'b0) begin bad++; $display("FAIL hw_done_t3: got %b want 0", bus.mem_done); end
      next_cycle();
      total++; if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 32'h0000_3CA5) begin bad++; $display("FAIL hw_done_t4: got done=%b rdata=%h want 1 00003ca5", bus.mem_done, bus.mem_rdata); end
      bus.mem_req = 1'b0; bus.flush_from_branch = 1'b0;
      next_cycle();
      $display("test_halfword_wrap done");
   endtask

   task automatic test_reset_mid_write();
      bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'b10;
      bus.mem_addr = 32'h500; bus.mem_wdata = 32'h1122_3344;
      next_cycle();
      total++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== {1'b1, 32'h500, 8'h44}) begin bad++; $display("FAIL rw_t1: got wr=%b addr=%h dout=%h want 1 00000500 44", bus.ram_wr, bus.ram_addr, bus.ram_dout); end
      next_cycle();
      total++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== {1'b1, 32'h501, 8'h33}) begin bad++; $display("FAIL rw_t2: got wr=%b addr=%h dout=%h want 1 00000501 33", bus.ram_wr, bus.ram_addr, bus.ram_dout); end
      next_cycle();
      total++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== {1'b1, 32'h502, 8'h22}) begin bad++; $display("FAIL rw_t3: got wr=%b addr=%h dout=%h want 1 00000502 22", bus.ram_wr, bus.ram_addr, bus.ram_dout); end
      rst = 1'b1;
      next_cycle();
      total++; if ({bus.ram_wr, bus.ram_addr, bus.ram_dout} !== 41'h0) begin bad++; $display("FAIL rw_t4_bus: got wr=%b addr=%h dout=%h want 0 0 0", bus.ram_wr, bus.ram_addr, bus.ram_dout); end
      total++; if ({bus.if_done, bus.mem_done, bus.if_inst, bus.mem_rdata} !== 66'h0) begin bad++; $display("FAIL rw_t4_outs: got done=%b%b inst=%h rdata=%h want all 0", bus.if_done, bus.mem_done, bus.if_inst, bus.mem_rdata); end
      rst = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
      for (int k = 5; k <= 8; k++) begin
         next_cycle();
         total++;
         if (bus.mem_done !== 1'b0 || bus.ram_wr !== 1'b0) begin bad++; $display("FAIL rw_quiet_t%0d: got done=%b wr=%b want 0 0", k, bus.mem_done, bus.ram_wr); end
      end
      total++; if (wr_mem.exists(32'h503) || !wr_mem.exists(32'h502) || wr_mem[32'h502] !== 8'h22) begin bad++; $display("FAIL rw_ram_contents: byte503 present=%0d byte502 present=%0d want 0 1", wr_mem.exists(32'h503), wr_mem.exists(32'h502)); end
      $display("test_reset_mid_write done");
   endtask

   initial begin
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'h0;
      bus.mem_len = 2'b00; bus.mem_wdata = 32'h0; bus.flush_from_branch = 1'b0;
      test_reset();
      test_fetch();
      test_simultaneous();
      test_byte_write();
      test_flush();
      test_halfword_wrap();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
